// File: rtl/sap_controller.sv
`default_nettype none
// ============================================================================
// Module      : sap_controller
// Description : SAP-1 style five-T-state sequencer and control-word decoder.
//               Optional macro SAP_COND_JUMP_EN enables JC (0x7) / JZ (0x8).
// Revision    : 1.0 - initial release
// ============================================================================
module sap_controller (
    input  logic        clk,
    input  logic        rst,
    input  logic        ena,
    input  logic [7:0]  instr,
    input  logic        cf_in,
    input  logic        zf_in,
    output logic [15:0] ctrl,
    output logic [2:0]  tstate,
    output logic [1:0]  flags
);

    typedef enum logic [2:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4
    } tstate_t;

    localparam int unsigned c_pc_inc     = 0;
    localparam int unsigned c_pc_out     = 1;
    localparam int unsigned c_pc_load    = 2;
    localparam int unsigned c_mar_load   = 3;
    localparam int unsigned c_ram_out    = 4;
    localparam int unsigned c_ram_in     = 5;
    localparam int unsigned c_ir_load    = 6;
    localparam int unsigned c_ir_out     = 7;
    localparam int unsigned c_a_load     = 8;
    localparam int unsigned c_a_out      = 9;
    localparam int unsigned c_b_load     = 10;
    localparam int unsigned c_alu_out    = 11;
    localparam int unsigned c_alu_sub    = 12;
    localparam int unsigned c_out_load   = 13;
    localparam int unsigned c_flags_load = 14;
    localparam int unsigned c_halt       = 15;

    localparam logic [3:0] c_op_lda = 4'h1;
    localparam logic [3:0] c_op_add = 4'h2;
    localparam logic [3:0] c_op_sub = 4'h3;
    localparam logic [3:0] c_op_sta = 4'h4;
    localparam logic [3:0] c_op_ldi = 4'h5;
    localparam logic [3:0] c_op_jmp = 4'h6;
    localparam logic [3:0] c_op_jc  = 4'h7;
    localparam logic [3:0] c_op_jz  = 4'h8;
    localparam logic [3:0] c_op_out = 4'hE;
    localparam logic [3:0] c_op_hlt = 4'hF;

    tstate_t     tstate_q, tstate_d;
    logic [1:0]  flags_q, flags_d;
    logic        halt_q, halt_d;
    logic [3:0]  w_op;
    logic [15:0] w_word;
    logic        w_unused_operand;

    assign w_op             = instr[7:4];
    assign w_unused_operand = ^instr[3:0];

    // Raw decode of the registered T-state; gating by rst/ena happens on the output.
    always_comb begin
        w_word = '0;
        if (halt_q) begin
            w_word[c_halt] = 1'b1;
        end else begin
            case (tstate_q)
                T0: begin
                    w_word[c_pc_out]   = 1'b1;
                    w_word[c_mar_load] = 1'b1;
                end
                T1: begin
                    w_word[c_ram_out] = 1'b1;
                    w_word[c_ir_load] = 1'b1;
                    w_word[c_pc_inc]  = 1'b1;
                end
                T2: begin
                    case (w_op)
                        c_op_lda, c_op_add, c_op_sub, c_op_sta: begin
                            w_word[c_ir_out]   = 1'b1;
                            w_word[c_mar_load] = 1'b1;
                        end
                        c_op_ldi: begin
                            w_word[c_ir_out] = 1'b1;
                            w_word[c_a_load] = 1'b1;
                        end
                        c_op_jmp: begin
                            w_word[c_ir_out]  = 1'b1;
                            w_word[c_pc_load] = 1'b1;
                        end
`ifdef SAP_COND_JUMP_EN
                        c_op_jc: begin
                            w_word[c_ir_out]  = flags_q[0];
                            w_word[c_pc_load] = flags_q[0];
                        end
                        c_op_jz: begin
                            w_word[c_ir_out]  = flags_q[1];
                            w_word[c_pc_load] = flags_q[1];
                        end
`endif
                        c_op_out: begin
                            w_word[c_a_out]    = 1'b1;
                            w_word[c_out_load] = 1'b1;
                        end
                        c_op_hlt: begin
                            w_word[c_halt] = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T3: begin
                    case (w_op)
                        c_op_lda: begin
                            w_word[c_ram_out] = 1'b1;
                            w_word[c_a_load]  = 1'b1;
                        end
                        c_op_add, c_op_sub: begin
                            w_word[c_ram_out] = 1'b1;
                            w_word[c_b_load]  = 1'b1;
                        end
                        c_op_sta: begin
                            w_word[c_a_out]  = 1'b1;
                            w_word[c_ram_in] = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T4: begin
                    if (w_op == c_op_add || w_op == c_op_sub) begin
                        w_word[c_alu_out]    = 1'b1;
                        w_word[c_a_load]     = 1'b1;
                        w_word[c_flags_load] = 1'b1;
                        w_word[c_alu_sub]    = (w_op == c_op_sub);
                    end
                end
                default: ;
            endcase
        end
    end

    assign ctrl   = (rst || !ena) ? 16'h0000 : w_word;
    assign tstate = tstate_q;
    assign flags  = flags_q;

    // HLT in T2 latches halt instead of advancing, so tstate parks at 2.
    always_comb begin
        tstate_d = tstate_q;
        flags_d  = flags_q;
        halt_d   = halt_q;
        if (ena && !halt_q) begin
            if (tstate_q == T2 && w_op == c_op_hlt) begin
                halt_d = 1'b1;
            end else begin
                if (w_word[c_flags_load]) begin
                    flags_d = {zf_in, cf_in};
                end
                case (tstate_q)
                    T0:      tstate_d = T1;
                    T1:      tstate_d = T2;
                    T2:      tstate_d = T3;
                    T3:      tstate_d = T4;
                    default: tstate_d = T0;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tstate_q <= T0;
            flags_q  <= 2'b00;
            halt_q   <= 1'b0;
        end else begin
            tstate_q <= tstate_d;
            flags_q  <= flags_d;
            halt_q   <= halt_d;
        end
    end

endmodule
`default_nettype wire
